// File: rtl/alu_share_arbiter.sv
// Two-port arbiter that shares one combinational ALU between the control unit (port 0) and an aux/debug master (port 1).
// Build option: define ARB_FIXED_PRIO_EN to make port 0 win every tie; the default build is round-robin.
//
// state | meaning
// IDLE  | waiting for a request; winner sees readyX and its op/a/b are latched
// EXEC  | latched op/a/b drive the ALU while the latency counter runs down to 0
// RESP  | one-cycle result pulse to the owning port
module alu_share_arbiter #(
    parameter int DATA_W    = 8,
    parameter int OP_W      = 8,
    parameter int MULTI_CYC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result
);
    localparam int CNT_W = (MULTI_CYC > 1) ? $clog2(MULTI_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              last_grant;
    logic              owner_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;

    logic              pick1, accept, in_exec, in_resp, sel_ok, sel_multi;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;

    always_comb begin
        pick1 = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        pick1 = req1_valid && !req0_valid;
`else
        pick1 = req1_valid && (!req0_valid || !last_grant);
`endif
        // Outputs are masked while reset is high so nothing escapes during the reset cycle.
        accept    = (state == IDLE) && !reset && (req0_valid || req1_valid);
        in_exec   = (state == EXEC) && !reset;
        in_resp   = (state == RESP) && !reset;
        sel_op    = pick1 ? req1_op : req0_op;
        sel_a     = pick1 ? req1_a  : req0_a;
        sel_b     = pick1 ? req1_b  : req0_b;
        sel_ok    = (sel_op != '0) && (sel_op <= OP_W'(14));
        sel_multi = (sel_op == OP_W'(3)) || (sel_op == OP_W'(4)) || (sel_op == OP_W'(5));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = sel_ok ? EXEC : RESP;
            EXEC:    if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= sel_op;
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        owner_q  <= pick1;
                        err_q    <= !sel_ok;
                        result_q <= '0;
                        cnt      <= sel_multi ? CNT_W'(MULTI_CYC - 1) : '0;
                    end
                end
                EXEC: begin
                    if (cnt == '0) result_q <= alu_result;
                    else           cnt      <= cnt - 1'b1;
                end
                RESP:    last_grant <= owner_q;
                default: ;
            endcase
        end
    end

    assign req0_ready = accept && !pick1;
    assign req1_ready = accept && pick1;
    assign alu_op     = in_exec ? op_q : '0;
    assign alu_a      = in_exec ? a_q  : '0;
    assign alu_b      = in_exec ? b_q  : '0;
    assign rsp0_valid = in_resp && !owner_q;
    assign rsp1_valid = in_resp && owner_q;
    assign rsp_result = in_resp ? result_q : '0;
    assign rsp_err    = in_resp && err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests push expected responses, a monitor pops and compares.
module tb_alu_share_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_op = '0, req0_a = '0, req0_b = '0;
    logic [7:0] req1_op = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
    logic [7:0] rsp_result, alu_op, alu_a, alu_b, alu_result;

    typedef struct {
        logic       port;
        logic [7:0] res;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    alu_share_arbiter #(.DATA_W(8), .OP_W(8), .MULTI_CYC(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
    );

    function automatic logic [7:0] alu_ref(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            8'h01: r = a + b;
            8'h02: r = a - b;
            8'h03: r = a * b;
            8'h04: r = (b == 0) ? 8'hFF : a / b;
            8'h05: r = (b == 0) ? a : a % b;
            8'h06: r = a & b;
            8'h0E: r = a | b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign alu_result = alu_ref(alu_op, alu_a, alu_b);

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if (rsp0_valid || rsp1_valid) begin
                if (rsp0_valid && rsp1_valid) begin
                    errors++;
                    $display("FAIL rsp_both: rsp0_valid and rsp1_valid both high at cycle %0d", cyc);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: port %0d result %h err %0d at cycle %0d, none expected",
                             rsp1_valid, rsp_result, rsp_err, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp1_valid !== e.port || rsp_result !== e.res || rsp_err !== e.err || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL rsp: got port %0d result %h err %0d cycle %0d, want port %0d result %h err %0d cycle %0d",
                                 rsp1_valid, rsp_result, rsp_err, cyc, e.port, e.res, e.err, e.cyc);
                    end
                end
            end else if (rsp_result !== 8'h00 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL rsp_idle: result %h err %0d without rsp valid at cycle %0d, want 00/0",
                         rsp_result, rsp_err, cyc);
            end
        end
    end

    task automatic check_zero(input string tag);
        logic [28:0] v;
        v = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, rsp_result, alu_op, alu_a, alu_b};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: outputs %h, want all 0", tag, v);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d responses still pending, want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_one(input string tag, input logic port, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_res, input logic exp_err, input int lat);
        bit got;
        @(posedge clock); #1;
        if (port) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (port ? req1_ready : req0_ready) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_accept: ready never seen, want ready on port %0d", tag, port);
        end else begin
            sb.push_back('{port, exp_res, exp_err, cyc + lat});
            checks++;
            if ((port ? req0_ready : req1_ready) !== 1'b0 || alu_op !== 8'h00) begin
                errors++;
                $display("FAIL %s_grant: other ready %0d alu_op %h at accept, want 0/00",
                         tag, port ? req0_ready : req1_ready, alu_op);
            end
        end
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0;
        if (got) begin
            for (int k = 1; k < lat; k++) begin
                @(negedge clock);
                checks++;
                if (alu_op !== op || alu_a !== a || alu_b !== b) begin
                    errors++;
                    $display("FAIL %s_alu: exec cycle %0d got op %h a %h b %h, want %h %h %h",
                             tag, k, alu_op, alu_a, alu_b, op, a, b);
                end
            end
            if (exp_err) begin
                @(negedge clock);
                checks++;
                if (alu_op !== 8'h00) begin
                    errors++;
                    $display("FAIL %s_alu_idle: alu_op %h for unsupported op, want 00", tag, alu_op);
                end
            end
        end
        drain(tag);
    endtask

    // Both ports held valid with the same single-cycle op; pat[i] is the expected winner of grant i.
    task automatic both_run(input string tag, input logic [7:0] op, input int n, input logic [7:0] pat);
        int done = 0;
        logic w;
        @(posedge clock); #1;
        req0_valid = 1; req0_op = op; req0_a = 8'd10; req0_b = 8'd3;
        req1_valid = 1; req1_op = op; req1_a = 8'd50; req1_b = 8'd8;
        for (int g = 0; g < 60 && done < n; g++) begin
            @(negedge clock);
            if (req0_ready || req1_ready) begin
                w = req1_ready;
                checks++;
                if (w !== pat[done] || (req0_ready && req1_ready)) begin
                    errors++;
                    $display("FAIL %s_grant%0d: ready0 %0d ready1 %0d, want winner %0d",
                             tag, done, req0_ready, req1_ready, pat[done]);
                end
                sb.push_back('{w, w ? alu_ref(op, req1_a, req1_b) : alu_ref(op, req0_a, req0_b), 1'b0, cyc + 2});
                done++;
                @(posedge clock); #1;
                if (done == n) begin req0_valid = 0; req1_valid = 0; end
                else if (w) req1_a = req1_a + 1;
                else        req0_a = req0_a + 1;
            end
        end
        req0_valid = 0; req1_valid = 0;
        checks++;
        if (done < n) begin
            errors++;
            $display("FAIL %s_count: %0d grants, want %0d", tag, done, n);
        end
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat4, pat2;
        int t;
        bit got;
`ifdef ARB_FIXED_PRIO_EN
        pat4 = 8'b0000_0000;
        pat2 = 8'b0000_0000;
`else
        pat4 = 8'b0000_1010;
        pat2 = 8'b0000_0010;
`endif
        repeat (3) @(posedge clock);
        #1 reset = 0;
        mon_en = 1;
        @(negedge clock);
        check_zero("reset_state");

        run_one("add", 1'b0, 8'h01, 8'd5, 8'd3, 8'd8, 1'b0, 2);
        run_one("mul", 1'b1, 8'h03, 8'd6, 8'd7, 8'h2A, 1'b0, 5);
        both_run("rr", 8'h02, 4, pat4);
        run_one("op00", 1'b0, 8'h00, 8'd9, 8'd9, 8'h00, 1'b1, 1);
        run_one("op0f", 1'b0, 8'h0F, 8'd9, 8'd9, 8'h00, 1'b1, 1);

        // Reset lands two cycles into a DIV; its response must never appear.
        @(posedge clock); #1;
        req0_valid = 1; req0_op = 8'h04; req0_a = 8'd20; req0_b = 8'd4;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (req0_ready) got = 1;
        end
        t = cyc;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL div_accept: req0_ready never seen, want 1");
        end
        @(posedge clock); #1;
        req0_valid = 0;
        @(negedge clock);
        checks++;
        if (alu_op !== 8'h04) begin
            errors++;
            $display("FAIL div_exec: alu_op %h at T+%0d, want 04", alu_op, cyc - t);
        end
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        check_zero("mid_reset");
        repeat (6) @(negedge clock);
        both_run("post_reset", 8'h01, 2, pat2);

        run_one("req1_add", 1'b1, 8'h01, 8'd1, 8'd2, 8'd3, 1'b0, 2);
        run_one("req1_again", 1'b1, 8'h0E, 8'h30, 8'h05, 8'h35, 1'b0, 2);

        repeat (5) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
